// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the received-frame loader: parser states,
// default sync bytes and the checksum width/accumulate helper.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_WID  = 3'd2,
    S_HGT  = 3'd3,
    S_PIX  = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;
  localparam int         CHK_W         = 8;

  // Modulo-2^CHK_W running sum of frame bytes.
  function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] sum,
                                               input logic [7:0]       data);
    return sum + data;
  endfunction

endpackage

// File: rtl/rx_frame_loader_if.sv
// Byte stream from the UART receiver plus the RAM write port of the loader.
// master = loader side, slave = receiver/RAM side.
interface rx_frame_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_byte;
  logic              rx_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              write;

  modport master (input rx_byte, rx_done, output ram_addr, ram_din, write);
  modport slave  (output rx_byte, rx_done, input ram_addr, ram_din, write);
endinterface

// File: rtl/rx_timeout_ctr.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags
// the cycle in which LIMIT idle cycles have elapsed.
module rx_timeout_ctr #(
  parameter int LIMIT = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int                CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0]  ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/rx_frame_loader.sv
// Parses SYNC0 SYNC1 W H pixels CHK frames from the UART byte stream, writes
// the pixels to RAM from BASE_ADDR and pulses frame_done / frame_err.
module rx_frame_loader
  import rx_frame_pkg::*;
#(
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = {ADDR_W{1'b0}},
  parameter logic [7:0]        SYNC0          = SYNC0_DEFAULT,
  parameter logic [7:0]        SYNC1          = SYNC1_DEFAULT,
  parameter int                TIMEOUT_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  rx_frame_loader_if.master  bus,
  output logic [7:0]         width,
  output logic [7:0]         height,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              write_q, write_d;
  logic [7:0]        width_q, width_d;
  logic [7:0]        height_q, height_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CHK_W-1:0]  sum_q, sum_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [15:0]       area_s;
  logic              tmo_expire_s;

  // Pixel count for the frame: latched width times the height byte in flight.
  assign area_s = {8'h00, width_q} * {8'h00, bus.rx_byte};

  rx_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.rx_done || (state_q == S_IDLE)),
    .enable (state_q != S_IDLE),
    .expire (tmo_expire_s)
  );

  // Parser next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    write_d     = 1'b0;
    width_d     = width_q;
    height_d    = height_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sum_d       = sum_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    // A byte arriving in the expiry cycle takes priority over the timeout.
    if (bus.rx_done) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_byte == SYNC0) state_d = S_SYNC;
          else                      state_d = S_IDLE;
        end
        S_SYNC: begin
          if (bus.rx_byte == SYNC1)      state_d = S_WID;
          else if (bus.rx_byte == SYNC0) state_d = S_SYNC;
          else                           state_d = S_IDLE;
        end
        S_WID: begin
          width_d = bus.rx_byte;
          sum_d   = bus.rx_byte;
          state_d = S_HGT;
        end
        S_HGT: begin
          height_d = bus.rx_byte;
          sum_d    = chk_add(sum_q, bus.rx_byte);
          if ((width_q == 8'h00) || (bus.rx_byte == 8'h00)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            remaining_d = area_s;
            index_d     = {ADDR_W{1'b0}};
            state_d     = S_PIX;
          end
        end
        S_PIX: begin
          write_d     = 1'b1;
          ram_addr_d  = BASE_ADDR + index_q;
          ram_din_d   = bus.rx_byte;
          sum_d       = chk_add(sum_q, bus.rx_byte);
          index_d     = index_q + ADDR_ONE;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = S_CHK;
          else                      state_d = S_PIX;
        end
        S_CHK: begin
          if (bus.rx_byte == sum_q) done_d = 1'b1;
          else                      err_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_expire_s) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ram_addr_q  <= BASE_ADDR;
      ram_din_q   <= 8'h00;
      write_q     <= 1'b0;
      width_q     <= 8'h00;
      height_q    <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sum_q       <= {CHK_W{1'b0}};
      remaining_q <= 16'h0000;
      index_q     <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      write_q     <= write_d;
      width_q     <= width_d;
      height_q    <= height_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.write    = write_q;
  assign width        = width_q;
  assign height       = height_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;

endmodule

// File: doc/rx_frame_loader.md
# rx_frame_loader

Upstream ingest stage between the UART receiver and the data RAM write port of the downsampling system. It parses framed image packets arriving as received bytes: sync word, width, height, pixel bytes and checksum. It writes pixels into consecutive RAM addresses from a base, and reports frame completion or error to the I/O controller, which then hands the RAM to the processor.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- BASE_ADDR, 16'h0000, RAM address of pixel 0
- SYNC0, 8'hA5, first sync byte
- SYNC1, 8'h5A, second sync byte
- TIMEOUT_CYCLES, 500000, max idle cycles between bytes inside a frame (≥2)

Ports:
- clk  in  1  system clock; the single clock for the block
- reset  in  1  synchronous, active-high reset
- rx_byte  in  8  received byte; valid in the cycle rx_done=1
- rx_done  in  1  one-cycle strobe per received byte
- ram_addr  out  ADDR_W  write address
- ram_din  out  8  write data
- write  out  1  one-cycle RAM write strobe
- width  out  8  latched frame width
- height  out  8  latched frame height
- busy  out  1  high in every state except S_IDLE
- frame_done  out  1  one-cycle pulse: frame accepted, checksum good
- frame_err  out  1  one-cycle pulse: frame aborted

## Operation
- Frame format: SYNC0, SYNC1, W, H, W*H pixel bytes, CHK. CHK = 8-bit modulo-256 sum of W, H and all pixels.
- States: S_IDLE, S_SYNC, S_WID, S_HGT, S_PIX, S_CHK. Transitions occur only on rx_done, except on timeout.
- S_IDLE: byte==SYNC0 → S_SYNC. Any other byte is ignored.
- S_SYNC: SYNC1 → S_WID. SYNC0 → stay in S_SYNC. Anything else → S_IDLE, with no error pulse.
- S_WID: latch width and reset the sum → S_HGT.
- S_HGT: latch height.
  - If W==0 or H==0: frame_err, → S_IDLE.
  - Otherwise: load remaining = W*H (16-bit unsigned product, max 65025), pixel index = 0 → S_PIX.
- S_PIX: on each byte, issue a RAM write of the byte at BASE_ADDR+index, add it to the sum, increment index, and decrement remaining. When remaining reaches 0 → S_CHK.
- S_CHK: byte==sum → frame_done. Otherwise → frame_err. Either way → S_IDLE.
- Pixels already written on an error are not rolled back.
- Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W.
- Timeout: a counter clears on every rx_done and whenever in S_IDLE. Reaching TIMEOUT_CYCLES in any non-idle state → frame_err, → S_IDLE.
- Timeout in S_SYNC also pulses frame_err.
- rx_done coinciding with timeout expiry: the byte is processed and the timeout is discarded.
- width and height hold their last latched values until the next S_WID/S_HGT.

## Timing
- Reset values: ram_addr=BASE_ADDR, ram_din=0, write=0, width=0, height=0, busy=0, frame_done=0, frame_err=0. State is S_IDLE, all counters and the sum are 0.
- Reset mid-frame: next cycle is S_IDLE with no write and no pulse.
- All outputs are registered.
- write, ram_addr and ram_din are valid together in the cycle after the rx_done that carried the pixel. Write is exactly one cycle wide.
- frame_done and frame_err go high in the cycle after the triggering rx_done (or the timeout cycle), for one cycle only. busy falls in that same cycle.
- Back-to-back rx_done strobes must be supported at a rate of one per cycle: a write every cycle, with no drops.
- A new SYNC0 arriving the cycle after frame_done is accepted.

## Structure
- Shared package rx_frame_pkg holds:
  - the state enum
  - SYNC0/SYNC1 defaults
  - the checksum width constant
- One sub-module, rx_timeout_ctr: a parameterised counter with clear, enable and expire outputs, instantiated once.
- The W*H multiply is a single combinational product registered in S_HGT.

## Test plan
- A5 5A 02 02 10 20 30 40 A4 → writes 10,20,30,40 at addresses 0..3; frame_done pulses; width=2, height=2.
- Same frame with CHK=00 → 4 writes, frame_err pulses once, frame_done never asserts.
- 00 A5 A5 5A 01 01 7F 81 → leading 00 ignored; the repeated A5 resynchronises; 1 write of 7F at addr 0; frame_done.
- A5 5A 00 03 → frame_err after the H byte, zero writes, busy back to 0.
- A5 5A 02 01 11, then idle for TIMEOUT_CYCLES → 1 write, frame_err exactly at the expiry cycle, back to S_IDLE.
- BASE_ADDR=16'hFFFE with a 2×2 frame sent at a byte every cycle → addresses FFFE, FFFF, 0000, 0001 on consecutive cycles. Assert reset during the 3rd pixel → no further writes, all outputs at reset values.
